// File: rtl/picorv_stream_master.sv
// picorv_stream_master
// Stream-driven initiator for the PicoRV32 native memory bus. Command packets
// arrive on a 32-bit valid/ready stream and are turned into word writes or
// reads. Read data and a per-packet status word leave on a 32-bit output
// stream.
//
// Packet: word0 = {op[31], ignored[30:8], len[7:0]}, word1 = byte address
// (low two bits forced to 0), then len data words for writes only.
// Status word: {8'hA5, 6'b0, to, op, 8'h00, done_cnt}.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   din, val_in, ready_upward      command/data input stream
//   dout, val_out, ready_downward  read data / status output stream
//   mem_*                          PicoRV32 native bus initiator side
//   busy                           packet in progress (state != IDLE)
//   err                            sticky bus timeout flag
module picorv_stream_master #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] din,
    input  logic        val_in,
    output logic        ready_upward,
    output logic [31:0] dout,
    output logic        val_out,
    input  logic        ready_downward,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int unsigned     LEN_W   = 8;
    localparam int unsigned     DATA_W  = 32;
    localparam logic            TO_EN   = 1'(TIMEOUT != 0);
    // Last count value before the access is abandoned; unused when TO_EN=0.
    localparam logic [CNT_BITS-1:0] TO_LAST = CNT_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_WDATA,
        S_WBUS,
        S_RBUS,
        S_RSEND,
        S_DRAIN,
        S_STAT
    } state_t;

    state_t              state_q,     state_d;
    logic                op_q,        op_d;
    logic                to_q,        to_d;
    logic [LEN_W-1:0]    rem_q,       rem_d;
    logic [LEN_W-1:0]    done_q,      done_d;
    logic [DATA_W-1:0]   addr_q,      addr_d;
    logic                mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   dout_q,      dout_d;
    logic                val_out_q,   val_out_d;
    logic                ready_q,     ready_d;
    logic                busy_q,      busy_d;
    logic                err_q,       err_d;
    logic [CNT_BITS-1:0] tcnt_q,      tcnt_d;

    logic                in_fire_c;
    logic                out_fire_c;
    logic                bus_done_c;
    logic                bus_to_c;
    logic [LEN_W-1:0]    done_inc_c;

    assign in_fire_c  = val_in && ready_q;
    assign out_fire_c = val_out_q && ready_downward;
    // mem_ready only counts while a request is actually outstanding.
    assign bus_done_c = mem_valid_q && mem_ready;
    // Completion on the final count cycle takes priority over the timeout.
    assign bus_to_c   = TO_EN && mem_valid_q && !mem_ready && (tcnt_q == TO_LAST);
    assign done_inc_c = (done_q == '1) ? done_q : done_q + LEN_W'(1);

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        to_d        = to_q;
        rem_d       = rem_q;
        done_d      = done_q;
        addr_d      = addr_q;
        mem_valid_d = mem_valid_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        dout_d      = dout_q;
        val_out_d   = val_out_q;
        err_d       = err_q;
        tcnt_d      = tcnt_q;

        if (mem_valid_q && !mem_ready) begin
            tcnt_d = tcnt_q + CNT_BITS'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (in_fire_c) begin
                    op_d    = din[31];
                    rem_d   = din[LEN_W-1:0];
                    done_d  = '0;
                    to_d    = 1'b0;
                    state_d = S_HDR1;
                end
            end

            S_HDR1: begin
                if (in_fire_c) begin
                    addr_d = {din[31:2], 2'b00};
                    if (rem_q == '0) begin
                        state_d = S_STAT;
                    end else if (op_q) begin
                        state_d = S_WDATA;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_wstrb_d = 4'h0;
                        tcnt_d      = '0;
                        state_d     = S_RBUS;
                    end
                end
            end

            S_WDATA: begin
                if (in_fire_c) begin
                    mem_wdata_d = din;
                    mem_wstrb_d = 4'hF;
                    mem_valid_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = S_WBUS;
                end
            end

            S_WBUS: begin
                if (bus_done_c) begin
                    mem_valid_d = 1'b0;
                    done_d      = done_inc_c;
                    addr_d      = addr_q + 32'd4;
                    rem_d       = rem_q - LEN_W'(1);
                    state_d     = (rem_q == LEN_W'(1)) ? S_STAT : S_WDATA;
                end else if (bus_to_c) begin
                    // The abandoned word is consumed; any remaining words are drained.
                    mem_valid_d = 1'b0;
                    to_d        = 1'b1;
                    err_d       = 1'b1;
                    rem_d       = rem_q - LEN_W'(1);
                    state_d     = (rem_q == LEN_W'(1)) ? S_STAT : S_DRAIN;
                end
            end

            S_RBUS: begin
                if (bus_done_c) begin
                    mem_valid_d = 1'b0;
                    dout_d      = mem_rdata;
                    val_out_d   = 1'b1;
                    state_d     = S_RSEND;
                end else if (bus_to_c) begin
                    mem_valid_d = 1'b0;
                    to_d        = 1'b1;
                    err_d       = 1'b1;
                    state_d     = S_STAT;
                end
            end

            S_RSEND: begin
                // Next read is only issued once the previous word has left.
                if (out_fire_c) begin
                    val_out_d = 1'b0;
                    done_d    = done_inc_c;
                    addr_d    = addr_q + 32'd4;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_STAT;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_wstrb_d = 4'h0;
                        tcnt_d      = '0;
                        state_d     = S_RBUS;
                    end
                end
            end

            S_DRAIN: begin
                if (in_fire_c) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_STAT;
                    end
                end
            end

            S_STAT: begin
                // Status is loaded one cycle after entry so a pending read word clears first.
                if (!val_out_q) begin
                    dout_d    = {8'hA5, 6'b0, to_q, op_q, 8'h00, done_q};
                    val_out_d = 1'b1;
                end else if (out_fire_c) begin
                    val_out_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered flags follow the state being entered.
        ready_d = (state_d == S_IDLE) || (state_d == S_HDR1) ||
                  (state_d == S_WDATA) || (state_d == S_DRAIN);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            to_q        <= 1'b0;
            rem_q       <= '0;
            done_q      <= '0;
            addr_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'h0;
            dout_q      <= '0;
            val_out_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            to_q        <= to_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            mem_valid_q <= mem_valid_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            dout_q      <= dout_d;
            val_out_q   <= val_out_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign ready_upward = ready_q;
    assign dout         = dout_q;
    assign val_out      = val_out_q;
    assign mem_valid    = mem_valid_q;
    assign mem_instr    = 1'b0;
    assign mem_addr     = addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule
